// File: rtl/load_store_unit.sv
// Load/store unit: takes one decode-side access at a time, aligns it onto a word-wide
// data-memory bus and returns sign/zero-extended load data or a misalignment error.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_req,
  input  logic                       mem_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic                       load_unsigned,
  input  logic [DATA_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic                       mem_valid,
  output logic                       mem_err,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       busy,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DATA_WIDTH-1:0]      dmem_addr,
  output logic [BYTE_DATA_WIDTH-1:0] dmem_be,
  output logic [DATA_WIDTH-1:0]      dmem_wdata,
  input  logic                       dmem_gnt,
  input  logic                       dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]      dmem_rdata
);

  // Decode side: mem_req is sampled only in IDLE; mem_valid is a one-cycle completion pulse.
  // Bus side: dmem_req/we/addr/be/wdata stay stable while dmem_req=1 until dmem_gnt;
  // dmem_rvalid is only honoured in WAIT_RD.

  localparam int OFF_W = $clog2(BYTE_DATA_WIDTH);

  localparam logic [BYTE_DATA_WIDTH-1:0] BE_BYTE = BYTE_DATA_WIDTH'(1);
  localparam logic [BYTE_DATA_WIDTH-1:0] BE_HALF = BYTE_DATA_WIDTH'(3);
  localparam logic [BYTE_DATA_WIDTH-1:0] BE_WORD = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_RESP     = 3'd3,
    S_ERR_RESP = 3'd4
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]      cap_addr;
  logic [OFF_W-1:0]           cap_off;
  logic [BYTE_DATA_WIDTH-1:0] cap_size;
  logic [BYTE_DATA_WIDTH-1:0] cap_be;
  logic [DATA_WIDTH-1:0]      cap_wdata;
  logic                       cap_we;
  logic                       cap_uns;
  logic [DATA_WIDTH-1:0]      rdata_q;

  logic                       accept;
  logic                       size_ok;
  logic                       align_ok;
  logic [DATA_WIDTH-1:0]      shifted;
  logic [DATA_WIDTH-1:0]      load_ext;

  assign accept = (state == S_IDLE) && mem_req;

  // Only byte, half and word sizes are legal; half/word must be naturally aligned.
  always_comb begin
    size_ok  = (byte_enable == BE_BYTE) || (byte_enable == BE_HALF) || (byte_enable == BE_WORD);
    align_ok = 1'b1;
    if (byte_enable == BE_HALF) align_ok = ~addr[0];
    else if (byte_enable == BE_WORD) align_ok = (addr[OFF_W-1:0] == '0);
  end

  always_comb begin
    shifted  = dmem_rdata >> {cap_off, 3'b000};
    load_ext = shifted;
    case (cap_size)
      BE_BYTE: load_ext = {{(DATA_WIDTH-8){~cap_uns & shifted[7]}}, shifted[7:0]};
      BE_HALF: load_ext = {{(DATA_WIDTH-16){~cap_uns & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (mem_req) state_next = (size_ok && align_ok) ? S_REQ : S_ERR_RESP;
      end
      S_REQ: begin
        if (dmem_gnt) state_next = cap_we ? S_RESP : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (dmem_rvalid) state_next = S_RESP;
      end
      S_RESP:     state_next = S_IDLE;
      S_ERR_RESP: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Lane alignment is done once at capture so the bus outputs come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr  <= '0;
      cap_off   <= '0;
      cap_size  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
      cap_uns   <= 1'b0;
    end else if (accept) begin
      cap_addr  <= {addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      cap_off   <= addr[OFF_W-1:0];
      cap_size  <= byte_enable;
      cap_be    <= byte_enable << addr[OFF_W-1:0];
      cap_wdata <= wdata << {addr[OFF_W-1:0], 3'b000};
      cap_we    <= mem_we;
      cap_uns   <= load_unsigned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if ((state == S_WAIT_RD) && dmem_rvalid) begin
      rdata_q <= load_ext;
    end
  end

  // Request and response strobes decode directly from state so an async reset clears them at once.
  always_comb begin
    busy       = (state != S_IDLE);
    dmem_req   = (state == S_REQ);
    dmem_we    = (state == S_REQ) && cap_we;
    dmem_addr  = cap_addr;
    dmem_be    = cap_be;
    dmem_wdata = cap_wdata;
    mem_valid  = (state == S_RESP) || (state == S_ERR_RESP);
    mem_err    = (state == S_ERR_RESP);
    rdata      = (state == S_ERR_RESP) ? '0 : rdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads with extension, misalignment,
// bus stall, stray rvalid and asynchronous reset mid-operation.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  byte_enable;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_valid;
  logic        mem_err;
  logic [31:0] rdata;
  logic        busy;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int cmp_cnt = 0;
  int err_cnt = 0;

  load_store_unit #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .byte_enable  (byte_enable),
    .load_unsigned(load_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .mem_valid    (mem_valid),
    .mem_err      (mem_err),
    .rdata        (rdata),
    .busy         (busy),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Presents one request for a single cycle; returns one cycle after the DUT sampled it.
  task automatic issue(input logic we, input logic [3:0] be, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    step();
    mem_req       = 1'b1;
    mem_we        = we;
    byte_enable   = be;
    load_unsigned = uns;
    addr          = a;
    wdata         = d;
    step();
    mem_req       = 1'b0;
  endtask

  // Load with gnt in the first REQ cycle and rvalid one cycle later; returns in the RESP cycle.
  task automatic do_load(input logic [3:0] be, input logic uns, input logic [31:0] a,
                         input logic [31:0] word);
    issue(1'b0, be, uns, a, 32'h0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = word;
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  initial begin
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; byte_enable = 4'h0; load_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

    // reset state
    step(); step();
    sample();
    check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_mem_err", {31'h0, mem_err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    step();
    rst = 1'b1;

    // SW 0x100: full-word store, gnt immediately, mem_valid two cycles after req
    issue(1'b1, 4'b1111, 1'b0, 32'h100, 32'hDEADBEEF);
    dmem_gnt = 1'b1;
    sample();
    check("sw_req", {31'h0, dmem_req}, 32'h1);
    check("sw_we", {31'h0, dmem_we}, 32'h1);
    check("sw_addr", dmem_addr, 32'h100);
    check("sw_be", {28'h0, dmem_be}, 32'hF);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    check("sw_no_early_valid", {31'h0, mem_valid}, 32'h0);
    step();
    dmem_gnt = 1'b0;
    sample();
    check("sw_valid", {31'h0, mem_valid}, 32'h1);
    check("sw_err", {31'h0, mem_err}, 32'h0);
    check("sw_req_drop", {31'h0, dmem_req}, 32'h0);
    step();
    sample();
    check("sw_valid_pulse", {31'h0, mem_valid}, 32'h0);
    check("sw_idle", {31'h0, busy}, 32'h0);

    // SB 0x103: top lane
    issue(1'b1, 4'b0001, 1'b0, 32'h103, 32'h000000A5);
    dmem_gnt = 1'b1;
    sample();
    check("sb_addr", dmem_addr, 32'h100);
    check("sb_be", {28'h0, dmem_be}, 32'h8);
    check("sb_wdata", dmem_wdata, 32'hA5000000);
    step();
    dmem_gnt = 1'b0;
    sample();
    check("sb_valid", {31'h0, mem_valid}, 32'h1);
    check("sb_err", {31'h0, mem_err}, 32'h0);
    check("sb_rdata_untouched", rdata, 32'h0);

    // LB 0x102 signed: byte 0xF3 sign-extends
    step();
    issue(1'b0, 4'b0001, 1'b0, 32'h102, 32'h0);
    dmem_gnt = 1'b1;
    sample();
    check("lb_we", {31'h0, dmem_we}, 32'h0);
    check("lb_be", {28'h0, dmem_be}, 32'h4);
    check("lb_addr", dmem_addr, 32'h100);
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12F34567;
    sample();
    check("lb_wait_req", {31'h0, dmem_req}, 32'h0);
    check("lb_wait_busy", {31'h0, busy}, 32'h1);
    check("lb_wait_no_valid", {31'h0, mem_valid}, 32'h0);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    sample();
    check("lb_valid", {31'h0, mem_valid}, 32'h1);
    check("lb_rdata", rdata, 32'hFFFFFFF3);
    step();
    sample();
    check("lb_rdata_hold", rdata, 32'hFFFFFFF3);

    // LBU 0x102: same byte zero-extended
    do_load(4'b0001, 1'b1, 32'h102, 32'h12F34567);
    sample();
    check("lbu_valid", {31'h0, mem_valid}, 32'h1);
    check("lbu_rdata", rdata, 32'h000000F3);

    // LH 0x101: misaligned, error response next cycle with no bus access
    step();
    issue(1'b0, 4'b0011, 1'b0, 32'h101, 32'h0);
    sample();
    check("lh_mis_valid", {31'h0, mem_valid}, 32'h1);
    check("lh_mis_err", {31'h0, mem_err}, 32'h1);
    check("lh_mis_rdata", rdata, 32'h0);
    check("lh_mis_req", {31'h0, dmem_req}, 32'h0);
    step();
    sample();
    check("lh_mis_done", {31'h0, mem_valid | dmem_req | busy}, 32'h0);
    check("lh_mis_rdata_hold", rdata, 32'h000000F3);

    // LH 0x102 signed: upper half 0x8001
    do_load(4'b0011, 1'b0, 32'h102, 32'h80011234);
    sample();
    check("lh_rdata", rdata, 32'hFFFF8001);

    // LW 0x104 passes the word through
    do_load(4'b1111, 1'b1, 32'h104, 32'hCAFEF00D);
    sample();
    check("lw_rdata", rdata, 32'hCAFEF00D);

    // Illegal size code
    step();
    issue(1'b1, 4'b0111, 1'b0, 32'h200, 32'h11111111);
    sample();
    check("bad_size_err", {31'h0, mem_err}, 32'h1);
    check("bad_size_req", {31'h0, dmem_req}, 32'h0);

    // SH 0x202 with gnt held low four cycles: bus outputs stable, valid one cycle after gnt
    step();
    issue(1'b1, 4'b0011, 1'b0, 32'h202, 32'h0000BEEF);
    for (int i = 0; i < 4; i++) begin
      sample();
      check("stall_req", {31'h0, dmem_req}, 32'h1);
      check("stall_addr", dmem_addr, 32'h200);
      check("stall_be", {28'h0, dmem_be}, 32'hC);
      check("stall_wdata", dmem_wdata, 32'hBEEF0000);
      check("stall_no_valid", {31'h0, mem_valid}, 32'h0);
      step();
    end
    dmem_gnt = 1'b1;
    sample();
    check("stall_gnt_req", {31'h0, dmem_req}, 32'h1);
    step();
    dmem_gnt = 1'b0;
    sample();
    check("stall_valid", {31'h0, mem_valid}, 32'h1);
    check("stall_rdata_kept", rdata, 32'hCAFEF00D);

    // Stray rvalid in IDLE is ignored
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55555555;
    step();
    dmem_rvalid = 1'b0;
    sample();
    check("stray_rvalid_valid", {31'h0, mem_valid}, 32'h0);
    check("stray_rvalid_rdata", rdata, 32'hCAFEF00D);

    // Async reset while in REQ drops dmem_req without a clock edge
    issue(1'b1, 4'b1111, 1'b0, 32'h300, 32'h0);
    sample();
    check("rreq_req_before", {31'h0, dmem_req}, 32'h1);
    #1 rst = 1'b0;
    #1;
    check("rreq_req_after", {31'h0, dmem_req}, 32'h0);
    check("rreq_busy_after", {31'h0, busy}, 32'h0);
    step();
    rst = 1'b1;

    // Async reset in WAIT_RD, then a late rvalid
    issue(1'b0, 4'b1111, 1'b0, 32'h300, 32'h0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rwait_req", {31'h0, dmem_req}, 32'h0);
    check("rwait_busy", {31'h0, busy}, 32'h0);
    check("rwait_rdata_cleared", rdata, 32'h0);
    step();
    rst         = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h87654321;
    step();
    dmem_rvalid = 1'b0;
    sample();
    check("late_rvalid_valid", {31'h0, mem_valid}, 32'h0);
    check("late_rvalid_busy", {31'h0, busy}, 32'h0);
    check("late_rvalid_rdata", rdata, 32'h0);
    step();
    sample();
    check("late_rvalid_valid2", {31'h0, mem_valid}, 32'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
